// File: rtl/elc_pkg.sv
// Shared definitions for the elevator call scheduler: default sizing,
// scheduler state encoding and a one-hot test used on the floor indicator.
package elc_pkg;

    localparam int NFLOORS_DEF      = 8;
    localparam int DWELL_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPATCH = 2'd2,
        DWELL    = 2'd3
    } elc_state_t;

    // Callers zero-extend narrower floor vectors to 64 bits.
    function automatic logic is_onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/elc_call_scheduler_if.sv
// Scheduler <-> motion controller link: one-hot target out, one-hot position
// and arrival strobe back.
interface elc_call_scheduler_if #(
    parameter int NFLOORS = 8
);
    logic [NFLOORS-1:0] request_floor;
    logic               req_valid;
    logic [NFLOORS-1:0] current_floor;
    logic               complete;

    modport master (
        output request_floor,
        output req_valid,
        input  current_floor,
        input  complete
    );

    modport slave (
        input  request_floor,
        input  req_valid,
        output current_floor,
        output complete
    );
endinterface

// File: rtl/elc_priority_pick.sv
// One-hot isolation of the lowest (or, with PICK_HIGHEST, highest) set bit.
// The highest-bit mode reverses the vector around the same lowest-bit trick.
module elc_priority_pick #(
    parameter int NFLOORS      = 8,
    parameter bit PICK_HIGHEST = 1'b0
) (
    input  logic [NFLOORS-1:0] vec,
    output logic [NFLOORS-1:0] pick,
    output logic               found
);

    logic [NFLOORS-1:0] src;
    logic [NFLOORS-1:0] low;

    genvar gi;
    generate
        for (gi = 0; gi < NFLOORS; gi++) begin : g_bit
            if (PICK_HIGHEST) begin : g_rev
                assign src[gi]  = vec[NFLOORS-1-gi];
                assign pick[gi] = low[NFLOORS-1-gi];
            end else begin : g_fwd
                assign src[gi]  = vec[gi];
                assign pick[gi] = low[gi];
            end
        end
    endgenerate

    assign low   = src & (~src + NFLOORS'(1));
    assign found = |vec;

endmodule

// File: rtl/elc_call_scheduler.sv
// SCAN call scheduler: latches call buttons, picks the next floor in the
// current sweep direction, dispatches it and holds a door dwell after arrival.
module elc_call_scheduler
    import elc_pkg::*;
#(
    parameter int NFLOORS      = NFLOORS_DEF,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int DWELL_W      = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NFLOORS-1:0] call_btn,
    input  logic               hold,
    elc_call_scheduler_if.master ctrl,
    output logic [NFLOORS-1:0] pending,
    output logic               dwell,
    output logic               sweep_up,
    output logic               floor_fault
);

    elc_state_t         state_reg, state_next;
    logic [NFLOORS-1:0] pending_reg, pending_next, serve_mask;
    logic [NFLOORS-1:0] request_reg, request_next;
    logic               req_valid_reg, req_valid_next;
    logic               sweep_up_reg, sweep_up_next;
    logic               floor_fault_reg;
    logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;

    logic [NFLOORS-1:0] cur, above, below, up_pick, dn_pick, pick, retarget_pick;
    logic               up_found, dn_found, pick_found, pick_rev, retarget, fault_now;

    assign cur       = ctrl.current_floor;
    assign fault_now = !is_onehot(64'(cur));
    assign below     = pending_reg & (cur - NFLOORS'(1));
    assign above     = pending_reg & ~(cur | (cur - NFLOORS'(1)));

    elc_priority_pick #(.NFLOORS(NFLOORS), .PICK_HIGHEST(1'b0)) u_pick_up (
        .vec(above), .pick(up_pick), .found(up_found)
    );
    elc_priority_pick #(.NFLOORS(NFLOORS), .PICK_HIGHEST(1'b1)) u_pick_dn (
        .vec(below), .pick(dn_pick), .found(dn_found)
    );

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        pick_rev   = 1'b0;
        if (sweep_up_reg) begin
            if (up_found) begin
                pick = up_pick; pick_found = 1'b1;
            end else if (dn_found) begin
                pick = dn_pick; pick_found = 1'b1; pick_rev = 1'b1;
            end
        end else begin
            if (dn_found) begin
                pick = dn_pick; pick_found = 1'b1;
            end else if (up_found) begin
                pick = up_pick; pick_found = 1'b1; pick_rev = 1'b1;
            end
        end
    end

    // One-hot vectors order the same as floor numbers, so a plain compare
    // tells whether the nearest call lies before the current target.
    assign retarget_pick = sweep_up_reg ? up_pick : dn_pick;
    assign retarget      = sweep_up_reg ? (up_found && (up_pick < request_reg))
                                        : (dn_found && (dn_pick > request_reg));

    always_comb begin
        state_next     = state_reg;
        request_next   = request_reg;
        req_valid_next = req_valid_reg;
        sweep_up_next  = sweep_up_reg;
        dwell_cnt_next = dwell_cnt_reg;
        serve_mask     = '0;
        // A bad position indication is caught the cycle it appears and held
        // off until the registered flag has also cleared.
        if (fault_now || floor_fault_reg) begin
            state_next     = IDLE;
            request_next   = '0;
            req_valid_next = 1'b0;
        end else if (!hold) begin
            case (state_reg)
                IDLE: begin
                    if (|(pending_reg & cur)) begin
                        serve_mask     = pending_reg & cur;
                        dwell_cnt_next = DWELL_W'(DWELL_CYCLES);
                        state_next     = DWELL;
                    end else if (pick_found) begin
                        state_next = SELECT;
                    end
                end
                SELECT: begin
                    if (pick_found) begin
                        request_next   = pick;
                        req_valid_next = 1'b1;
                        sweep_up_next  = sweep_up_reg ^ pick_rev;
                        state_next     = DISPATCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
                DISPATCH: begin
                    if (ctrl.complete && (cur == request_reg)) begin
                        serve_mask     = request_reg;
                        request_next   = '0;
                        req_valid_next = 1'b0;
                        dwell_cnt_next = DWELL_W'(DWELL_CYCLES);
                        state_next     = DWELL;
                    end else if (retarget) begin
                        request_next = retarget_pick;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_reg <= DWELL_W'(1)) begin
                        dwell_cnt_next = '0;
                        state_next     = IDLE;
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg - DWELL_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign pending_next = (pending_reg | call_btn) & ~serve_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            pending_reg     <= '0;
            request_reg     <= '0;
            req_valid_reg   <= 1'b0;
            sweep_up_reg    <= 1'b1;
            floor_fault_reg <= 1'b0;
            dwell_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            request_reg     <= request_next;
            req_valid_reg   <= req_valid_next;
            sweep_up_reg    <= sweep_up_next;
            floor_fault_reg <= fault_now;
            dwell_cnt_reg   <= dwell_cnt_next;
        end
    end

    assign ctrl.request_floor = request_reg;
    assign ctrl.req_valid     = req_valid_reg;
    assign pending            = pending_reg;
    assign dwell              = (state_reg == DWELL);
    assign sweep_up           = sweep_up_reg;
    assign floor_fault        = floor_fault_reg;

endmodule

// File: tb/tb_elc_call_scheduler.sv
// Bench for elc_call_scheduler: directed scenarios with fixed expectations,
// then a randomized car/button run against a floor-index SCAN model.
module tb_elc_call_scheduler;

    localparam int NF = 8;
    localparam int DW = 16;
    localparam int P_IDLE = 0, P_CHOOSE = 1, P_MOVING = 2, P_DOORS = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NF-1:0] call_btn;
    logic          hold;
    logic [NF-1:0] pending;
    logic          dwell, sweep_up, floor_fault;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_pend [NF];
    int m_phase, m_target, m_left;
    bit m_valid, m_up, m_fault;

    elc_call_scheduler_if #(.NFLOORS(NF)) bus ();

    elc_call_scheduler #(.NFLOORS(NF), .DWELL_CYCLES(DW), .DWELL_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .call_btn(call_btn), .hold(hold),
        .ctrl(bus), .pending(pending), .dwell(dwell), .sweep_up(sweep_up),
        .floor_fault(floor_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic nearest(input int cur, output int p, output bit rev);
        int lo_above = -1;
        int hi_below = -1;
        for (int i = NF - 1; i > cur; i--) if (m_pend[i]) lo_above = i;
        for (int i = 0; i < cur; i++) if (m_pend[i]) hi_below = i;
        p = -1; rev = 0;
        if (m_up) begin
            if (lo_above >= 0) p = lo_above;
            else if (hi_below >= 0) begin p = hi_below; rev = 1; end
        end else begin
            if (hi_below >= 0) p = hi_below;
            else if (lo_above >= 0) begin p = lo_above; rev = 1; end
        end
    endtask

    task automatic model_step(input logic [NF-1:0] btn, input logic hld,
                              input logic [NF-1:0] cf, input logic cmp, output int served);
        int cur = -1;
        int ones = 0;
        int p;
        bit rev, bad;
        served = -1;
        for (int i = 0; i < NF; i++) if (cf[i]) begin ones++; cur = i; end
        bad = (ones != 1);
        if (bad || m_fault) begin
            m_phase = P_IDLE; m_target = -1; m_valid = 0;
        end else if (!hld) begin
            case (m_phase)
                P_IDLE: begin
                    if (m_pend[cur]) begin
                        served = cur; m_phase = P_DOORS; m_left = DW;
                    end else begin
                        nearest(cur, p, rev);
                        if (p >= 0) m_phase = P_CHOOSE;
                    end
                end
                P_CHOOSE: begin
                    nearest(cur, p, rev);
                    if (p >= 0) begin
                        m_target = p; m_valid = 1; m_phase = P_MOVING;
                        if (rev) m_up = !m_up;
                    end else m_phase = P_IDLE;
                end
                P_MOVING: begin
                    if (cmp && cur == m_target) begin
                        served = cur; m_target = -1; m_valid = 0;
                        m_phase = P_DOORS; m_left = DW;
                    end else if (m_up) begin
                        for (int i = m_target - 1; i > cur; i--) if (m_pend[i]) m_target = i;
                    end else begin
                        for (int i = m_target + 1; i < cur; i++) if (m_pend[i]) m_target = i;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_IDLE;
                end
            endcase
        end
        for (int i = 0; i < NF; i++) if (btn[i]) m_pend[i] = 1;
        if (served >= 0) m_pend[served] = 0;
        m_fault = bad;
    endtask

    task automatic test_reset;
        reset_n = 1'b1; call_btn = '0; hold = 1'b0;
        bus.current_floor = 8'h01; bus.complete = 1'b0;
        #1 reset_n = 1'b0;
        cyc(3);
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
        checks++; if (bus.request_floor !== 8'h00) begin errors++; $display("FAIL reset_request: got %h want 00", bus.request_floor); end
        checks++; if (bus.req_valid !== 1'b0 || dwell !== 1'b0 || floor_fault !== 1'b0) begin
            errors++; $display("FAIL reset_flags: valid=%b dwell=%b fault=%b want 0 0 0", bus.req_valid, dwell, floor_fault); end
        checks++; if (sweep_up !== 1'b1) begin errors++; $display("FAIL reset_sweep: got %b want 1", sweep_up); end
        reset_n = 1'b1;
        $display("reset done");
    endtask

    task automatic test_basic_call;
        int n = 0;
        call_btn = 8'h10;
        cyc(1); call_btn = '0;
        checks++; if (pending !== 8'h10 || bus.req_valid !== 1'b0) begin
            errors++; $display("FAIL basic_latch: pending=%h valid=%b want 10 0", pending, bus.req_valid); end
        cyc(2);
        checks++; if (bus.request_floor !== 8'h10 || bus.req_valid !== 1'b1) begin
            errors++; $display("FAIL basic_dispatch: req=%h valid=%b want 10 1", bus.request_floor, bus.req_valid); end
        bus.current_floor = 8'h10; bus.complete = 1'b1;
        cyc(1); bus.complete = 1'b0;
        checks++; if (pending !== 8'h00 || bus.req_valid !== 1'b0 || bus.request_floor !== 8'h00) begin
            errors++; $display("FAIL basic_arrive: pending=%h valid=%b req=%h want 00 0 00", pending, bus.req_valid, bus.request_floor); end
        while (dwell === 1'b1 && n < 40) begin n++; cyc(1); end
        checks++; if (n != DW) begin errors++; $display("FAIL basic_dwell_len: got %0d want %0d", n, DW); end
        $display("call floor 4 served, dwell %0d cycles", n);
    endtask

    task automatic test_reversal;
        int n = 0;
        bus.current_floor = 8'h08; call_btn = 8'h81;
        cyc(1); call_btn = '0;
        cyc(2);
        checks++; if (bus.request_floor !== 8'h80 || sweep_up !== 1'b1) begin
            errors++; $display("FAIL rev_first: req=%h up=%b want 80 1", bus.request_floor, sweep_up); end
        bus.current_floor = 8'h80; bus.complete = 1'b1;
        cyc(1); bus.complete = 1'b0;
        checks++; if (pending !== 8'h01) begin errors++; $display("FAIL rev_pending: got %h want 01", pending); end
        while (dwell === 1'b1 && n < 40) begin n++; cyc(1); end
        cyc(2);
        checks++; if (bus.request_floor !== 8'h01 || sweep_up !== 1'b0 || bus.req_valid !== 1'b1) begin
            errors++; $display("FAIL rev_second: req=%h up=%b valid=%b want 01 0 1", bus.request_floor, sweep_up, bus.req_valid); end
        bus.current_floor = 8'h01; bus.complete = 1'b1;
        cyc(1); bus.complete = 1'b0;
        n = 0;
        while (dwell === 1'b1 && n < 40) begin n++; cyc(1); end
        checks++; if (n != DW || pending !== 8'h00) begin
            errors++; $display("FAIL rev_done: dwell=%0d pending=%h want %0d 00", n, pending, DW); end
        $display("reversal 80 then 01 served");
    endtask

    task automatic test_retarget;
        bus.current_floor = 8'h02; call_btn = 8'h40;
        cyc(1); call_btn = '0;
        cyc(2);
        checks++; if (bus.request_floor !== 8'h40 || sweep_up !== 1'b1) begin
            errors++; $display("FAIL retarget_initial: req=%h up=%b want 40 1", bus.request_floor, sweep_up); end
        call_btn = 8'h08;
        cyc(1); call_btn = '0;
        cyc(1);
        checks++; if (bus.request_floor !== 8'h08 || pending !== 8'h48) begin
            errors++; $display("FAIL retarget_switch: req=%h pending=%h want 08 48", bus.request_floor, pending); end
        bus.current_floor = 8'h08; bus.complete = 1'b1;
        cyc(1); bus.complete = 1'b0;
        checks++; if (pending !== 8'h40 || dwell !== 1'b1 || bus.req_valid !== 1'b0) begin
            errors++; $display("FAIL retarget_arrive: pending=%h dwell=%b valid=%b want 40 1 0", pending, dwell, bus.req_valid); end
        $display("retarget 40 -> 08 served");
    endtask

    task automatic test_hold_dwell;
        int n = 0;
        cyc(11);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            call_btn = (i == 2) ? 8'h01 : 8'h00;
            cyc(1);
            checks++; if (dwell !== 1'b1) begin errors++; $display("FAIL hold_dwell[%0d]: got %b want 1", i, dwell); end
        end
        call_btn = '0;
        checks++; if (pending !== 8'h41) begin errors++; $display("FAIL hold_pending: got %h want 41", pending); end
        hold = 1'b0;
        while (dwell === 1'b1 && n < 40) begin n++; cyc(1); end
        checks++; if (n != 5) begin errors++; $display("FAIL hold_resume: dwell cycles %0d want 5", n); end
        $display("hold released, dwell finished after %0d cycles", n);
    endtask

    task automatic test_floor_fault;
        cyc(2);
        checks++; if (bus.request_floor !== 8'h40 || bus.req_valid !== 1'b1) begin
            errors++; $display("FAIL fault_pre: req=%h valid=%b want 40 1", bus.request_floor, bus.req_valid); end
        bus.current_floor = 8'h06;
        cyc(1);
        checks++; if (floor_fault !== 1'b1 || bus.req_valid !== 1'b0) begin
            errors++; $display("FAIL fault_set: fault=%b valid=%b want 1 0", floor_fault, bus.req_valid); end
        call_btn = 8'h04;
        cyc(1); call_btn = '0;
        checks++; if (pending !== 8'h45 || floor_fault !== 1'b1) begin
            errors++; $display("FAIL fault_accum: pending=%h fault=%b want 45 1", pending, floor_fault); end
        bus.current_floor = 8'h04;
        cyc(1);
        checks++; if (floor_fault !== 1'b0 || bus.req_valid !== 1'b0) begin
            errors++; $display("FAIL fault_clear: fault=%b valid=%b want 0 0", floor_fault, bus.req_valid); end
        cyc(1);
        checks++; if (dwell !== 1'b1 || pending !== 8'h41) begin
            errors++; $display("FAIL fault_resume: dwell=%b pending=%h want 1 41", dwell, pending); end
        $display("floor fault raised and cleared, floor 2 served");
    endtask

    task automatic test_reset_midop;
        reset_n = 1'b0;
        #2;
        checks++; if (pending !== 8'h00 || dwell !== 1'b0) begin
            errors++; $display("FAIL midop_reset: pending=%h dwell=%b want 00 0", pending, dwell); end
        $display("async reset mid-dwell");
    endtask

    task automatic test_random;
        int car = 0;
        int served;
        logic [NF-1:0] exp_req, exp_pend, btn_v, cf_v;
        for (int i = 0; i < NF; i++) m_pend[i] = 0;
        m_phase = P_IDLE; m_target = -1; m_left = 0; m_valid = 0; m_up = 1; m_fault = 0;
        call_btn = '0; hold = 1'b0; bus.complete = 1'b0; bus.current_floor = 8'h01;
        cyc(2);
        reset_n = 1'b1;
        for (int cyc_i = 0; cyc_i < 1500; cyc_i++) begin
            btn_v = '0;
            if ($urandom_range(0, 5) == 0) btn_v[$urandom_range(0, NF - 1)] = 1'b1;
            call_btn = btn_v;
            hold = ($urandom_range(0, 19) == 0);
            if (m_valid && car != m_target && $urandom_range(0, 2) == 0)
                car = car + ((m_target > car) ? 1 : -1);
            bus.complete = 1'b0;
            if (m_valid && car == m_target && $urandom_range(0, 1) == 0) bus.complete = 1'b1;
            else if ($urandom_range(0, 15) == 0) bus.complete = 1'b1;
            cf_v = '0; cf_v[car] = 1'b1;
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 0) cf_v = '0;
                else cf_v[(car + 3) % NF] = 1'b1;
            end
            bus.current_floor = cf_v;
            @(posedge clk);
            model_step(btn_v, hold, cf_v, bus.complete, served);
            #1;
            if (served >= 0) $display("cycle %0d: served floor %0d", cyc_i, served);
            exp_req = '0; if (m_target >= 0) exp_req[m_target] = 1'b1;
            for (int i = 0; i < NF; i++) exp_pend[i] = m_pend[i];
            checks++; if (pending !== exp_pend) begin errors++; $display("FAIL rnd_pending @%0d: got %h want %h", cyc_i, pending, exp_pend); end
            checks++; if (bus.request_floor !== exp_req) begin errors++; $display("FAIL rnd_request @%0d: got %h want %h", cyc_i, bus.request_floor, exp_req); end
            checks++; if (bus.req_valid !== m_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc_i, bus.req_valid, m_valid); end
            checks++; if (dwell !== (m_phase == P_DOORS)) begin errors++; $display("FAIL rnd_dwell @%0d: got %b want %b", cyc_i, dwell, (m_phase == P_DOORS)); end
            checks++; if (sweep_up !== m_up) begin errors++; $display("FAIL rnd_sweep @%0d: got %b want %b", cyc_i, sweep_up, m_up); end
            checks++; if (floor_fault !== m_fault) begin errors++; $display("FAIL rnd_fault @%0d: got %b want %b", cyc_i, floor_fault, m_fault); end
        end
        hold = 1'b0; call_btn = '0; bus.complete = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_call();
        test_reversal();
        test_retarget();
        test_hold_dwell();
        test_floor_fault();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elc_call_scheduler.md
Name: elc_call_scheduler

Overview:
Upstream stage of the elevator controller. Latches car/hall call buttons into a pending set and chooses the next target floor using a direction-preserving sweep (SCAN). It drives the controller's one-hot request_floor and consumes its one-hot current-floor and complete outputs. After each arrival it holds a door-dwell interval, then dispatches the next call.

Parameters:
NFLOORS, 8, number of floors; width of all one-hot floor vectors.
DWELL_CYCLES, 16, clk cycles the door-dwell indication stays high after an arrival (>=1).
DWELL_W, 5, dwell counter width; must hold DWELL_CYCLES.

Ports:
clk  in  1  single system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
call_btn  in  NFLOORS  call buttons, bit i = floor i; a high level for 1+ cycles registers a call.
current_floor  in  NFLOORS  one-hot current floor from the controller.
complete  in  1  controller arrived at request_floor.
hold  in  1  door/weight alarm active (over_time OR over_weight); freezes the scheduler.
request_floor  out  NFLOORS  one-hot target to the controller; all-zero when no target.
req_valid  out  1  request_floor is a live target.
pending  out  NFLOORS  latched unserved calls.
dwell  out  1  door-dwell interval active.
sweep_up  out  1  current sweep direction; 1 = up.
floor_fault  out  1  current_floor is not one-hot.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - pending = 0, request_floor = 0, req_valid = 0, dwell = 0, floor_fault = 0.
  - sweep_up = 1; FSM = IDLE; dwell counter = 0.
- pending update, each cycle: pending <= (pending | call_btn) & ~serve_mask.
  - serve_mask is the floor being cleared this cycle.
  - Clear wins over a simultaneous press of the same floor.
- floor_fault is registered: 1 when current_floor is zero or has more than one bit set.
  - While floor_fault = 1 the FSM is forced to IDLE, req_valid = 0, and pending keeps accumulating.
- Selection (combinational, one pick):
  - above = pending bits strictly above current_floor; below = pending bits strictly below.
  - sweep_up = 1: lowest set bit of above. If none, reverse: highest set bit of below, and toggle sweep_up.
  - sweep_up = 0: mirror of the above.
  - Neither set: no pick.
- FSM states and transitions:
  - IDLE:
    - pending & current_floor != 0 -> clear that bit, go to DWELL.
    - Otherwise any pick -> SELECT.
  - SELECT (1 cycle): register the pick into request_floor; update sweep_up if reversed; go to DISPATCH.
  - DISPATCH: req_valid = 1.
    - Retarget: if a pending floor lies strictly between current_floor and request_floor in the sweep direction, request_floor is replaced by the nearer floor on the next cycle.
    - complete = 1 and current_floor == request_floor -> clear that pending bit, set request_floor = 0 and req_valid = 0, go to DWELL.
  - DWELL: dwell = 1 for exactly DWELL_CYCLES cycles (counter counts down), then -> IDLE.
- hold = 1 (any state):
  - Counter and FSM freeze; outputs keep their values; pending still accumulates.
  - Release resumes from the same state and count.
- complete while not in DISPATCH, or with a current_floor mismatch: ignored.
- Latency:
  - Button press to pending bit: 1 cycle.
  - IDLE with pending to req_valid high: 2 cycles (IDLE -> SELECT -> DISPATCH).
- reset_n low mid-operation: all state clears immediately; pending calls are lost.

Decomposition:
- Shared package elc_pkg holds:
  - localparams NFLOORS_DEF = 8 and DWELL_CYCLES_DEF = 16.
  - FSM state encoding: IDLE, SELECT, DISPATCH, DWELL (2-bit).
  - Helper function is_onehot.
- One sub-module, elc_priority_pick: parameterised NFLOORS, input vector plus mode (lowest/highest set bit), output one-hot pick and found flag.
  - Instantiate it twice: lowest-of-above, highest-of-below.

Test Plan:
- Reset with call_btn = 8'h00 and current_floor = 8'h01 -> all outputs at reset values, sweep_up = 1, req_valid = 0.
- current_floor = 8'h01, pulse call_btn = 8'h10 for 1 cycle:
  - pending = 8'h10 next cycle; request_floor = 8'h10 with req_valid = 1 two cycles later.
  - Drive current_floor = 8'h10 with complete = 1 -> pending = 0, dwell high for exactly 16 cycles.
- current_floor = 8'h08, sweep_up = 1, pending = 8'h81 -> serve 8'h80 first, then reverse: sweep_up = 0, request_floor = 8'h01.
- Target 8'h40 while car at 8'h02; press call_btn = 8'h08 -> request_floor retargets to 8'h08 next cycle; 8'h40 stays pending.
- Assert hold for 10 cycles mid-DWELL (counter at 5) -> dwell held and counter frozen; after release, dwell ends 5 cycles later.
- Drive current_floor = 8'h06 -> floor_fault = 1 next cycle, req_valid = 0; restore 8'h04 -> fault clears and scheduling resumes.
